// File: rtl/banked_dp_ram.sv
// Dual-port RAM built from NUM_BANKS low-order-interleaved single-port banks.
// Ports hitting different banks proceed in parallel; same-bank collisions go through a 1-bit round-robin.
module banked_dp_ram #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int NUM_BANKS = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [CNT_W-1:0]  conflict_cnt,
    input  logic              clr_cnt
);
    localparam int BANK_LOG = $clog2(NUM_BANKS);
    localparam int BANK_W   = (BANK_LOG > 0) ? BANK_LOG : 1;
    localparam int ROW_W    = (ADDR_W > BANK_LOG) ? ADDR_W - BANK_LOG : 1;
    localparam int DEPTH    = 2 ** (ADDR_W - BANK_LOG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [BANK_W-1:0] bank_t;
    typedef logic [ROW_W-1:0]  row_t;

    function automatic bank_t bank_of(input logic [ADDR_W-1:0] addr);
        return bank_t'(addr & ADDR_W'(NUM_BANKS - 1));
    endfunction

    function automatic row_t row_of(input logic [ADDR_W-1:0] addr);
        return row_t'(addr >> BANK_LOG);
    endfunction

    bank_t a_bank, b_bank;
    row_t  a_row, b_row;
    logic  conflict;

    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_rvalid_q, b_rvalid_q;
    bank_t             a_rbank_q, b_rbank_q;
    logic [DATA_W-1:0] a_hold_q, b_hold_q;
    logic [DATA_W-1:0] a_bank_data, b_bank_data;
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    assign a_bank = bank_of(a_addr);
    assign b_bank = bank_of(b_addr);
    assign a_row  = row_of(a_addr);
    assign b_row  = row_of(b_addr);

    // With a single bank both indices are 0, so every dual request collides.
    assign conflict = rst_n & a_req & b_req & (a_bank == b_bank);
    assign a_ready  = rst_n & a_req & ~(conflict & rr_q);
    assign b_ready  = rst_n & b_req & ~(conflict & ~rr_q);

    // NOTE: every variable of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rr_d  = rr_q;
        cnt_d = cnt_q;
        if (conflict) begin
            rr_d = ~rr_q;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
        if (clr_cnt) cnt_d = '0;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rbank_q  <= '0;
            b_rbank_q  <= '0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_ready & ~a_we;
            b_rvalid_q <= b_ready & ~b_we;
            if (a_ready & ~a_we) a_rbank_q <= a_bank;
            if (b_ready & ~b_we) b_rbank_q <= b_bank;
            if (a_rvalid_q) a_hold_q <= a_bank_data;
            if (b_rvalid_q) b_hold_q <= b_bank_data;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic              sel_a, sel_b, en, we;
        row_t              row;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rd_q;
        logic [DATA_W-1:0] mem [DEPTH];

        // Arbitration guarantees at most one of sel_a / sel_b per cycle.
        assign sel_a = a_ready & (a_bank == bank_t'(g));
        assign sel_b = b_ready & (b_bank == bank_t'(g));
        assign en    = sel_a | sel_b;
        assign we    = sel_a ? a_we    : b_we;
        assign row   = sel_a ? a_row   : b_row;
        assign wdata = sel_a ? a_wdata : b_wdata;

        // NOTE: the storage array and its read register are deliberately left without reset so they map onto RAM.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we) mem[row] <= wdata;
                else    rd_q     <= mem[row];
            end
        end

        assign bank_rdata[g] = rd_q;
    end

    always_comb begin
        a_bank_data = '0;
        b_bank_data = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (a_rbank_q == bank_t'(i)) a_bank_data |= bank_rdata[i];
            if (b_rbank_q == bank_t'(i)) b_bank_data |= bank_rdata[i];
        end
    end

    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_rdata      = a_rvalid_q ? a_bank_data : a_hold_q;
    assign b_rdata      = b_rvalid_q ? b_bank_data : b_hold_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_banked_dp_ram.sv
// Bench for banked_dp_ram: directed scenarios on the default build plus randomized
// dual-port traffic against an array-based reference memory over several parameter sets.
module tb_banked_dp_ram;
    localparam int NCFG = 5;
    localparam int AW   = 10;

    function automatic int cfg_dw(input int i);
        case (i)
            2:       return 8;
            3:       return 128;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_nb(input int i);
        case (i)
            2:       return 1;
            3:       return 2;
            4:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_cw(input int i);
        return (i == 1) ? 4 : 16;
    endfunction

    logic clk = 1'b0;
    logic rst_n;

    logic          a_req [NCFG], a_we [NCFG], b_req [NCFG], b_we [NCFG], clr_cnt [NCFG];
    logic [AW-1:0] a_addr [NCFG], b_addr [NCFG];
    logic [127:0]  a_wdata [NCFG], b_wdata [NCFG];
    logic          a_ready [NCFG], b_ready [NCFG], a_rvalid [NCFG], b_rvalid [NCFG];
    logic [127:0]  a_rdata [NCFG], b_rdata [NCFG];
    logic [15:0]   cnt [NCFG];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int DW = cfg_dw(g);
        localparam int CW = cfg_cw(g);
        logic [DW-1:0] a_rd, b_rd;
        logic [CW-1:0] cnt_w;

        banked_dp_ram #(
            .DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(cfg_nb(g)), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .a_req(a_req[g]), .a_we(a_we[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g][DW-1:0]),
            .a_ready(a_ready[g]), .a_rvalid(a_rvalid[g]), .a_rdata(a_rd),
            .b_req(b_req[g]), .b_we(b_we[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g][DW-1:0]),
            .b_ready(b_ready[g]), .b_rvalid(b_rvalid[g]), .b_rdata(b_rd),
            .conflict_cnt(cnt_w), .clr_cnt(clr_cnt[g])
        );

        assign a_rdata[g] = 128'(a_rd);
        assign b_rdata[g] = 128'(b_rd);
        assign cnt[g]     = 16'(cnt_w);
    end

    task automatic idle_all();
        for (int i = 0; i < NCFG; i++) begin
            a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0;
            b_req[i] = 1'b0; b_we[i] = 1'b0; b_addr[i] = '0; b_wdata[i] = '0;
            clr_cnt[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_a(input int c, input bit req, input bit we, input int addr, input logic [127:0] wd);
        a_req[c] = req; a_we[c] = we; a_addr[c] = AW'(addr); a_wdata[c] = wd;
    endtask

    task automatic drive_b(input int c, input bit req, input bit we, input int addr, input logic [127:0] wd);
        b_req[c] = req; b_we[c] = we; b_addr[c] = AW'(addr); b_wdata[c] = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_a(0, 1, 0, 0, '0);
        drive_b(0, 1, 0, 4, '0);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (a_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %0b want 0", a_ready[0]); end
            checks++; if (b_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_b_ready got %0b want 0", b_ready[0]); end
            checks++; if (a_rvalid[0] !== 1'b0 || b_rvalid[0] !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b%0b want 00", a_rvalid[0], b_rvalid[0]); end
            checks++; if (a_rdata[0] !== '0 || b_rdata[0] !== '0) begin errors++; $display("FAIL rst_rdata got %0h/%0h want 0", a_rdata[0], b_rdata[0]); end
            checks++; if (cnt[0] !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", cnt[0]); end
            repeat (2) @(negedge clk);
            #1;
        end
        idle_all();
        rst_n = 1'b1;
    endtask

    task automatic test_parallel();
        do_reset();
        @(negedge clk);
        drive_a(0, 1, 1, 'h004, 128'hDEAD_BEEF);
        drive_b(0, 1, 1, 'h005, 128'h1234_5678);
        #1;
        checks++; if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b1) begin errors++; $display("FAIL par_wr_ready got %0b%0b want 11", a_ready[0], b_ready[0]); end
        @(negedge clk);
        drive_a(0, 1, 0, 'h004, '0);
        drive_b(0, 1, 0, 'h005, '0);
        #1;
        checks++; if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b1) begin errors++; $display("FAIL par_rd_ready got %0b%0b want 11", a_ready[0], b_ready[0]); end
        checks++; if (a_rvalid[0] !== 1'b0 || b_rvalid[0] !== 1'b0) begin errors++; $display("FAIL par_wr_rvalid got %0b%0b want 00", a_rvalid[0], b_rvalid[0]); end
        @(negedge clk);
        idle_all();
        #1;
        checks++; if (a_ready[0] !== 1'b0 || b_ready[0] !== 1'b0) begin errors++; $display("FAIL par_idle_ready got %0b%0b want 00", a_ready[0], b_ready[0]); end
        checks++; if (a_rvalid[0] !== 1'b1 || b_rvalid[0] !== 1'b1) begin errors++; $display("FAIL par_rvalid got %0b%0b want 11", a_rvalid[0], b_rvalid[0]); end
        checks++; if (a_rdata[0] !== 128'hDEAD_BEEF) begin errors++; $display("FAIL par_a_rdata got %0h want deadbeef", a_rdata[0]); end
        checks++; if (b_rdata[0] !== 128'h1234_5678) begin errors++; $display("FAIL par_b_rdata got %0h want 12345678", b_rdata[0]); end
        checks++; if (cnt[0] !== 16'd0) begin errors++; $display("FAIL par_cnt got %0d want 0", cnt[0]); end
        @(negedge clk);
        #1;
        checks++; if (a_rvalid[0] !== 1'b0 || b_rvalid[0] !== 1'b0) begin errors++; $display("FAIL par_pulse got %0b%0b want 00", a_rvalid[0], b_rvalid[0]); end
        checks++; if (a_rdata[0] !== 128'hDEAD_BEEF || b_rdata[0] !== 128'h1234_5678) begin errors++; $display("FAIL par_hold got %0h/%0h", a_rdata[0], b_rdata[0]); end
    endtask

    task automatic test_conflict_rr();
        do_reset();
        @(negedge clk);
        drive_a(0, 1, 0, 'h002, '0);
        drive_b(0, 1, 0, 'h006, '0);
        #1;
        checks++; if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b0) begin errors++; $display("FAIL rr_cyc1 got a%0b b%0b want a1 b0", a_ready[0], b_ready[0]); end
        @(negedge clk);
        a_req[0] = 1'b0;
        #1;
        checks++; if (b_ready[0] !== 1'b1) begin errors++; $display("FAIL rr_cyc2 got b%0b want b1", b_ready[0]); end
        checks++; if (a_rvalid[0] !== 1'b1) begin errors++; $display("FAIL rr_a_rvalid got %0b want 1", a_rvalid[0]); end
        checks++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL rr_cnt1 got %0d want 1", cnt[0]); end
        // Pointer held through the non-conflict cycle, so B is still favoured.
        @(negedge clk);
        drive_a(0, 1, 0, 'h001, '0);
        drive_b(0, 1, 0, 'h005, '0);
        #1;
        checks++; if (b_rvalid[0] !== 1'b1 || a_rvalid[0] !== 1'b0) begin errors++; $display("FAIL rr_rvalid got a%0b b%0b want a0 b1", a_rvalid[0], b_rvalid[0]); end
        checks++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL rr_cnt_hold got %0d want 1", cnt[0]); end
        checks++; if (a_ready[0] !== 1'b0 || b_ready[0] !== 1'b1) begin errors++; $display("FAIL rr_favour_b got a%0b b%0b want a0 b1", a_ready[0], b_ready[0]); end
        @(negedge clk);
        idle_all();
        #1;
        checks++; if (cnt[0] !== 16'd2) begin errors++; $display("FAIL rr_cnt2 got %0d want 2", cnt[0]); end
    endtask

    task automatic test_same_addr();
        do_reset();
        @(negedge clk);
        drive_a(0, 1, 1, 'h010, 128'hAAAA_0001);
        drive_b(0, 1, 0, 'h010, '0);
        #1;
        checks++; if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b0) begin errors++; $display("FAIL same_cyc1 got a%0b b%0b want a1 b0", a_ready[0], b_ready[0]); end
        @(negedge clk);
        a_req[0] = 1'b0;
        #1;
        checks++; if (b_ready[0] !== 1'b1) begin errors++; $display("FAIL same_cyc2 got b%0b want b1", b_ready[0]); end
        @(negedge clk);
        idle_all();
        #1;
        checks++; if (b_rvalid[0] !== 1'b1) begin errors++; $display("FAIL same_rvalid got %0b want 1", b_rvalid[0]); end
        checks++; if (b_rdata[0] !== 128'hAAAA_0001) begin errors++; $display("FAIL same_rdata got %0h want aaaa0001", b_rdata[0]); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_a(1, 1, 0, 'h000, '0);
            drive_b(1, 1, 0, 'h004, '0);
            #1;
            checks++; if (cnt[1] !== 16'((i < 15) ? i : 15)) begin errors++; $display("FAIL sat_cnt i=%0d got %0d want %0d", i, cnt[1], (i < 15) ? i : 15); end
        end
        @(negedge clk);
        clr_cnt[1] = 1'b1;
        #1;
        checks++; if (cnt[1] !== 16'd15) begin errors++; $display("FAIL sat_top got %0d want 15", cnt[1]); end
        @(negedge clk);
        clr_cnt[1] = 1'b0;
        #1;
        checks++; if (cnt[1] !== 16'd0) begin errors++; $display("FAIL sat_clr_wins got %0d want 0", cnt[1]); end
        @(negedge clk);
        idle_all();
        clr_cnt[1] = 1'b1;
        #1;
        checks++; if (cnt[1] !== 16'd1) begin errors++; $display("FAIL sat_restart got %0d want 1", cnt[1]); end
        @(negedge clk);
        clr_cnt[1] = 1'b0;
        #1;
        checks++; if (cnt[1] !== 16'd0) begin errors++; $display("FAIL sat_clr_idle got %0d want 0", cnt[1]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        drive_a(0, 1, 1, 'h008, 128'h5A5A_1234);
        @(negedge clk);
        drive_a(0, 1, 0, 'h008, '0);
        #1;
        checks++; if (a_ready[0] !== 1'b1) begin errors++; $display("FAIL ar_accept got %0b want 1", a_ready[0]); end
        @(negedge clk);
        idle_all();
        #1;
        checks++; if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 128'h5A5A_1234) begin errors++; $display("FAIL ar_pre got v%0b d%0h want v1 d5a5a1234", a_rvalid[0], a_rdata[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_rvalid[0] !== 1'b0) begin errors++; $display("FAIL ar_rvalid_now got %0b want 0", a_rvalid[0]); end
        checks++; if (a_rdata[0] !== '0) begin errors++; $display("FAIL ar_rdata_now got %0h want 0", a_rdata[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (a_rvalid[0] !== 1'b0 || a_rdata[0] !== '0) begin errors++; $display("FAIL ar_after i=%0d got v%0b d%0h want v0 d0", i, a_rvalid[0], a_rdata[0]); end
        end
    endtask

    task automatic test_random(input int c, input int ncyc);
        int           nb;
        logic [127:0] mask;
        logic [127:0] model [32];
        bit           pa, pb, awe, bwe, conf, ea, eb, rr, exp_arv, exp_brv;
        int           aad, bad, ecnt;
        logic [127:0] awd, bwd, exp_ard, exp_brd;

        nb   = cfg_nb(c);
        mask = (cfg_dw(c) == 128) ? '1 : ((128'd1 << cfg_dw(c)) - 128'd1);
        do_reset();
        pa = 0; pb = 0; awe = 0; bwe = 0; aad = 0; bad = 0; awd = '0; bwd = '0;
        rr = 0; ecnt = 0; exp_arv = 0; exp_brv = 0; exp_ard = '0; exp_brd = '0;

        for (int cyc = 0; cyc < ncyc; cyc++) begin
            // First 32 cycles fill the address window from port A so later reads are defined.
            if (!pa && cyc < 32) begin
                pa = 1; awe = 1; aad = cyc; awd = {$urandom, $urandom, $urandom, $urandom} & mask;
            end else if (!pa && $urandom_range(0, 9) < 7) begin
                pa = 1; awe = bit'($urandom_range(0, 1)); aad = $urandom_range(0, 31);
                awd = {$urandom, $urandom, $urandom, $urandom} & mask;
            end
            if (!pb && cyc >= 32 && $urandom_range(0, 9) < 7) begin
                pb = 1; bwe = bit'($urandom_range(0, 1)); bad = $urandom_range(0, 31);
                bwd = {$urandom, $urandom, $urandom, $urandom} & mask;
            end

            @(negedge clk);
            drive_a(c, pa, awe, aad, awd);
            drive_b(c, pb, bwe, bad, bwd);
            #1;

            checks++; if (a_rvalid[c] !== exp_arv || a_rdata[c] !== exp_ard) begin errors++; $display("FAIL rnd%0d a_resp cyc=%0d got v%0b d%0h want v%0b d%0h", c, cyc, a_rvalid[c], a_rdata[c], exp_arv, exp_ard); end
            checks++; if (b_rvalid[c] !== exp_brv || b_rdata[c] !== exp_brd) begin errors++; $display("FAIL rnd%0d b_resp cyc=%0d got v%0b d%0h want v%0b d%0h", c, cyc, b_rvalid[c], b_rdata[c], exp_brv, exp_brd); end

            conf = pa && pb && ((aad % nb) == (bad % nb));
            ea   = pa && (!conf || !rr);
            eb   = pb && (!conf || rr);
            checks++; if (a_ready[c] !== ea || b_ready[c] !== eb) begin errors++; $display("FAIL rnd%0d ready cyc=%0d got a%0b b%0b want a%0b b%0b", c, cyc, a_ready[c], b_ready[c], ea, eb); end
            checks++; if (cnt[c] !== 16'(ecnt)) begin errors++; $display("FAIL rnd%0d cnt cyc=%0d got %0d want %0d", c, cyc, cnt[c], ecnt); end

            exp_arv = ea && !awe;
            exp_brv = eb && !bwe;
            if (exp_arv) exp_ard = model[aad];
            if (exp_brv) exp_brd = model[bad];
            if (ea && awe) model[aad] = awd;
            if (eb && bwe) model[bad] = bwd;
            if (conf) begin
                rr = !rr;
                if (ecnt < 65535) ecnt++;
            end
            if (ea) pa = 0;
            if (eb) pb = 0;
        end

        @(negedge clk);
        idle_all();
        #1;
        checks++; if (a_rvalid[c] !== exp_arv || a_rdata[c] !== exp_ard) begin errors++; $display("FAIL rnd%0d a_last got v%0b d%0h want v%0b d%0h", c, a_rvalid[c], a_rdata[c], exp_arv, exp_ard); end
        checks++; if (b_rvalid[c] !== exp_brv || b_rdata[c] !== exp_brd) begin errors++; $display("FAIL rnd%0d b_last got v%0b d%0h want v%0b d%0h", c, b_rvalid[c], b_rdata[c], exp_brv, exp_brd); end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_all();
        #2;
        test_reset();
        test_parallel();
        test_conflict_rr();
        test_same_addr();
        test_saturation();
        test_async_reset();
        test_random(0, 400);
        test_random(2, 400);
        test_random(3, 400);
        test_random(4, 400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
